// File: rtl/riptide_pipe_pkg.sv
// rtl/riptide_pipe_pkg.sv - shared types for the decode-stage hazard sequencer
// Contents:
//   sb_entry_t  one in-flight write: register-file and I/O-latch destinations
//   hz_state_t  sequencer FSM states
//   SB_BUBBLE   empty scoreboard slot (both write enables low)
package riptide_pipe_pkg;

    typedef struct packed {
        logic       regf_wren;
        logic [2:0] regf_w;
        logic       latch_wren;
        logic [1:0] latch_addr;
    } sb_entry_t;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_FLUSH = 1'b1
    } hz_state_t;

    localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - decode-stage controls exchanged with the hazard sequencer
// Signals:
//   p_cache_miss                 fetch miss, decode is injecting NOPs
//   d_regf_wren/d_regf_w         registered destination of the decoded instr
//   d_latch_wren/d_latch_addr    registered latch destination of the decoded instr
//   d_branch                     decoded instr is a control transfer
//   s_reg_rd/s_regf_a            source register of the instr being decoded
//   s_latch_rd/s_latch_addr      source latch of the instr being decoded
//   hazard                       stall decode this cycle
//   flush                        squash fetch/decode this cycle
// Modports: master = decode side, slave = hazard_ctrl
interface hazard_ctrl_if;

    logic       p_cache_miss;
    logic       d_regf_wren;
    logic [2:0] d_regf_w;
    logic       d_latch_wren;
    logic [1:0] d_latch_addr;
    logic       d_branch;
    logic       s_reg_rd;
    logic [2:0] s_regf_a;
    logic       s_latch_rd;
    logic [1:0] s_latch_addr;
    logic       hazard;
    logic       flush;

    modport master (
        output p_cache_miss, d_regf_wren, d_regf_w, d_latch_wren, d_latch_addr,
               d_branch, s_reg_rd, s_regf_a, s_latch_rd, s_latch_addr,
        input  hazard, flush
    );

    modport slave (
        input  p_cache_miss, d_regf_wren, d_regf_w, d_latch_wren, d_latch_addr,
               d_branch, s_reg_rd, s_regf_a, s_latch_rd, s_latch_addr,
        output hazard, flush
    );

endinterface

// File: rtl/sb_match.sv
// rtl/sb_match.sv - compare one in-flight write against the decoding instr's sources
// Ports:
//   entry         in  sb_entry_t  in-flight write
//   s_regf_a      in  3           source register being read
//   s_latch_addr  in  2           source latch being read
//   reg_hit       out 1           entry writes s_regf_a
//   latch_hit     out 1           entry writes s_latch_addr
module sb_match
    import riptide_pipe_pkg::*;
(
    input  sb_entry_t  entry,
    input  logic [2:0] s_regf_a,
    input  logic [1:0] s_latch_addr,
    output logic       reg_hit,
    output logic       latch_hit
);

    assign reg_hit   = entry.regf_wren  && (entry.regf_w     == s_regf_a);
    assign latch_hit = entry.latch_wren && (entry.latch_addr == s_latch_addr);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-stage RAW stall and branch-shadow flush sequencer
// Parameters: DEPTH (scoreboard stages, 1..4), BRANCH_SHADOW (flush cycles, 1..7),
//             STAT_W (statistics width, HAZARD_STATS_EN only)
// Ports:
//   clk        in   clock, rising edge
//   n_RST      in   asynchronous active-low reset
//   bus        slave modport of hazard_ctrl_if (decode controls in, hazard/flush out)
//   stall_cnt  out  saturating count of hazard cycles (HAZARD_STATS_EN only)
//   flush_cnt  out  saturating count of flush cycles  (HAZARD_STATS_EN only)
// Build option: define HAZARD_STATS_EN to add the statistics counters.
module hazard_ctrl
    import riptide_pipe_pkg::*;
#(
    parameter int DEPTH         = 2,
    parameter int BRANCH_SHADOW = 2
`ifdef HAZARD_STATS_EN
    ,
    parameter int STAT_W        = 16
`endif
) (
    input  logic          clk,
    input  logic          n_RST,
    hazard_ctrl_if.slave  bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
`endif
);

    localparam logic [2:0] SHADOW_LOAD = 3'(BRANCH_SHADOW - 1);
    localparam logic [2:0] HZ_MAX      = 3'(DEPTH + 1);

    logic       issued_q;
    sb_entry_t  sb [DEPTH];
    sb_entry_t  d_entry;
    sb_entry_t  cur_entry;
    logic [DEPTH:0] reg_hit;
    logic [DEPTH:0] latch_hit;
    logic       hazard;
    hz_state_t  state;
    logic [2:0] shadow_cnt;
    logic       flush_q;
    logic [2:0] hz_run;

    assign d_entry   = {bus.d_regf_wren, bus.d_regf_w, bus.d_latch_wren, bus.d_latch_addr};
    // d_* only carry an instruction when it actually issued last edge
    assign cur_entry = issued_q ? d_entry : SB_BUBBLE;

    // One comparator per scoreboard stage plus one for the instruction sitting
    // on d_* right now: there is no forwarding, so it must stall readers too.
    for (genvar k = 0; k <= DEPTH; k++) begin : g_match
        if (k < DEPTH) begin : g_sb
            sb_match u_match (
                .entry        (sb[k]),
                .s_regf_a     (bus.s_regf_a),
                .s_latch_addr (bus.s_latch_addr),
                .reg_hit      (reg_hit[k]),
                .latch_hit    (latch_hit[k])
            );
        end else begin : g_cur
            sb_match u_match (
                .entry        (cur_entry),
                .s_regf_a     (bus.s_regf_a),
                .s_latch_addr (bus.s_latch_addr),
                .reg_hit      (reg_hit[k]),
                .latch_hit    (latch_hit[k])
            );
        end
    end

    // Flush squashes the decoding instruction anyway, so a stall is meaningless then
    assign hazard = ~flush_q & ((bus.s_reg_rd & (|reg_hit)) | (bus.s_latch_rd & (|latch_hit)));

    assign bus.hazard = hazard;
    assign bus.flush  = flush_q;

    // Issue tracking and scoreboard; the shift never stalls so entries always drain
    always_ff @(posedge clk or negedge n_RST) begin
        if (!n_RST) begin
            issued_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                sb[k] <= SB_BUBBLE;
            end
        end else begin
            issued_q <= ~hazard & ~flush_q & ~bus.p_cache_miss;
            for (int k = DEPTH - 1; k > 0; k--) begin
                sb[k] <= sb[k-1];
            end
            sb[0] <= cur_entry;
        end
    end

    // Branch-shadow FSM; a branch seen while already flushing cannot have issued
    always_ff @(posedge clk or negedge n_RST) begin
        if (!n_RST) begin
            state      <= HZ_RUN;
            shadow_cnt <= 3'd0;
            flush_q    <= 1'b0;
        end else begin
            case (state)
                HZ_RUN: begin
                    if (issued_q && bus.d_branch) begin
                        state      <= HZ_FLUSH;
                        shadow_cnt <= SHADOW_LOAD;
                        flush_q    <= 1'b1;
                    end
                end
                HZ_FLUSH: begin
                    if (shadow_cnt == 3'd0) begin
                        state   <= HZ_RUN;
                        flush_q <= 1'b0;
                    end else begin
                        shadow_cnt <= shadow_cnt - 3'd1;
                    end
                end
                default: begin
                    state   <= HZ_RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge n_RST) begin
        if (!n_RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hazard && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_q && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

    // A stall blocks issue, so the newest matching write retires within DEPTH+1 cycles
    always_ff @(posedge clk or negedge n_RST) begin
        if (!n_RST) begin
            hz_run <= 3'd0;
        end else begin
            hz_run <= hazard ? hz_run + 3'd1 : 3'd0;
        end
    end

    stall_bound: assert property (@(posedge clk) disable iff (!n_RST) !(hazard && (hz_run == HZ_MAX)));

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic n_RST;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if bus ();

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    hazard_ctrl #(
        .DEPTH         (2),
        .BRANCH_SHADOW (2)
    ) dut (
        .clk       (clk),
        .n_RST     (n_RST),
        .bus       (bus)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    task automatic clear_inputs();
        bus.p_cache_miss = 1'b0;
        bus.d_regf_wren  = 1'b0;
        bus.d_regf_w     = 3'd0;
        bus.d_latch_wren = 1'b0;
        bus.d_latch_addr = 2'd0;
        bus.d_branch     = 1'b0;
        bus.s_reg_rd     = 1'b0;
        bus.s_regf_a     = 3'd0;
        bus.s_latch_rd   = 1'b0;
        bus.s_latch_addr = 2'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT with an empty scoreboard and issued_q=1 in the current cycle
    task automatic idle(input int n);
        clear_inputs();
        repeat (n) step();
    endtask

    task automatic test_reset();
        n_RST = 1'b0;
        clear_inputs();
        bus.d_regf_wren = 1'b1;
        bus.s_reg_rd    = 1'b1;
        bus.d_branch    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.hazard !== 1'b0) begin
            errors++;
            $display("FAIL reset_hazard got=%b exp=0", bus.hazard);
        end
        checks++;
        if (bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush got=%b exp=0", bus.flush);
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters got=%h/%h exp=0/0", stall_cnt, flush_cnt);
        end
`endif
        step();
        n_RST = 1'b1;
        clear_inputs();
    endtask

    // Register RAW on r3 and latch RAW on addr 2: stall lasts DEPTH+1 cycles
    task automatic test_raw();
        logic [3:0] exp_hz;
        exp_hz = 4'b0111;
        for (int v = 0; v < 2; v++) begin
            idle(4);
            for (int i = 0; i < 4; i++) begin
                if (i > 0) step();
                clear_inputs();
                if (v == 0) begin
                    bus.d_regf_wren = (i == 0);
                    bus.d_regf_w    = 3'd3;
                    bus.s_reg_rd    = 1'b1;
                    bus.s_regf_a    = 3'd3;
                end else begin
                    bus.d_latch_wren = (i == 0);
                    bus.d_latch_addr = 2'd2;
                    bus.s_latch_rd   = 1'b1;
                    bus.s_latch_addr = 2'd2;
                end
                @(negedge clk);
                checks++;
                if (bus.hazard !== exp_hz[i]) begin
                    errors++;
                    $display("FAIL raw_v%0d_c%0d hazard got=%b exp=%b", v, i, bus.hazard, exp_hz[i]);
                end
            end
        end
        idle(4);
    endtask

    // Writes to a different register / latch never stall
    task automatic test_no_match();
        for (int v = 0; v < 2; v++) begin
            idle(4);
            for (int i = 0; i < 4; i++) begin
                if (i > 0) step();
                clear_inputs();
                if (v == 0) begin
                    bus.d_regf_wren = (i == 0);
                    bus.d_regf_w    = 3'd3;
                    bus.s_reg_rd    = 1'b1;
                    bus.s_regf_a    = 3'd4;
                end else begin
                    bus.d_latch_wren = (i == 0);
                    bus.d_latch_addr = 2'd2;
                    bus.s_latch_rd   = 1'b1;
                    bus.s_latch_addr = 2'd1;
                end
                @(negedge clk);
                checks++;
                if (bus.hazard !== 1'b0) begin
                    errors++;
                    $display("FAIL nomatch_v%0d_c%0d hazard got=%b exp=0", v, i, bus.hazard);
                end
            end
        end
        idle(4);
    endtask

    // Branch issued in c0 (and a second one presented in c1): flush in c1,c2 only
    task automatic test_branch();
        logic [4:0] exp_fl;
        exp_fl = 5'b00110;
        idle(4);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            clear_inputs();
            bus.d_branch = (i < 2);
            @(negedge clk);
            checks++;
            if (bus.flush !== exp_fl[i]) begin
                errors++;
                $display("FAIL branch_c%0d flush got=%b exp=%b", i, bus.flush, exp_fl[i]);
            end
            checks++;
            if (bus.hazard !== 1'b0) begin
                errors++;
                $display("FAIL branch_c%0d hazard got=%b exp=0", i, bus.hazard);
            end
        end
        idle(4);
    endtask

    // r5 write, then branch issues while r5 is read: flush masks the stall, r5 drains
    task automatic test_branch_raw();
        logic [4:0] exp_hz;
        logic [4:0] exp_fl;
        exp_hz = 5'b00010;
        exp_fl = 5'b01100;
        idle(4);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            clear_inputs();
            bus.d_regf_wren = (i == 0);
            bus.d_regf_w    = 3'd5;
            bus.d_branch    = (i == 1);
            bus.s_reg_rd    = (i >= 1);
            bus.s_regf_a    = 3'd5;
            @(negedge clk);
            checks++;
            if (bus.hazard !== exp_hz[i]) begin
                errors++;
                $display("FAIL brraw_c%0d hazard got=%b exp=%b", i, bus.hazard, exp_hz[i]);
            end
            checks++;
            if (bus.flush !== exp_fl[i]) begin
                errors++;
                $display("FAIL brraw_c%0d flush got=%b exp=%b", i, bus.flush, exp_fl[i]);
            end
        end
        idle(4);
    endtask

    // r2 in sb[0] while fetch misses for 4 cycles; the held r2 write on d_* only
    // stalls once a cycle without miss/hazard lets it issue
    task automatic test_cache_miss();
        logic [6:0] exp_hz;
        exp_hz = 7'b1000110;
        idle(4);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            clear_inputs();
            bus.p_cache_miss = (i >= 1) && (i <= 4);
            bus.d_regf_wren  = (i == 0) || (i >= 3);
            bus.d_regf_w     = 3'd2;
            bus.s_reg_rd     = (i >= 1);
            bus.s_regf_a     = 3'd2;
            @(negedge clk);
            checks++;
            if (bus.hazard !== exp_hz[i]) begin
                errors++;
                $display("FAIL miss_c%0d hazard got=%b exp=%b", i, bus.hazard, exp_hz[i]);
            end
        end
        idle(4);
    endtask

    task automatic test_reset_mid();
        // mid-FLUSH
        idle(4);
        bus.d_branch = 1'b1;
        step();
        bus.d_branch = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL rstfl_pre flush got=%b exp=1", bus.flush);
        end
        n_RST = 1'b0;
        #1;
        checks++;
        if (bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL rstfl_async flush got=%b exp=0", bus.flush);
        end
        step();
        n_RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.flush !== 1'b0) begin
                errors++;
                $display("FAIL rstfl_after_c%0d flush got=%b exp=0", i, bus.flush);
            end
            step();
        end
        // mid-stall
        idle(4);
        bus.d_regf_wren = 1'b1;
        bus.d_regf_w    = 3'd3;
        bus.s_reg_rd    = 1'b1;
        bus.s_regf_a    = 3'd3;
        @(negedge clk);
        checks++;
        if (bus.hazard !== 1'b1) begin
            errors++;
            $display("FAIL rsthz_pre hazard got=%b exp=1", bus.hazard);
        end
        n_RST = 1'b0;
        #1;
        checks++;
        if (bus.hazard !== 1'b0) begin
            errors++;
            $display("FAIL rsthz_async hazard got=%b exp=0", bus.hazard);
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_counters got=%h/%h exp=0/0", stall_cnt, flush_cnt);
        end
`endif
        step();
        n_RST = 1'b1;
        bus.d_regf_wren = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.hazard !== 1'b0) begin
                errors++;
                $display("FAIL rsthz_after_c%0d hazard got=%b exp=0", i, bus.hazard);
            end
            step();
        end
        idle(4);
    endtask

`ifdef HAZARD_STATS_EN
    // Counters start from the reset in test_reset_mid: one 3-cycle stall, one 2-cycle flush
    task automatic test_stats();
        bus.d_regf_wren = 1'b1;
        bus.d_regf_w    = 3'd1;
        bus.s_reg_rd    = 1'b1;
        bus.s_regf_a    = 3'd1;
        step();
        bus.d_regf_wren = 1'b0;
        step();
        step();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stats_stall got=%0d exp=3", stall_cnt);
        end
        idle(4);
        bus.d_branch = 1'b1;
        step();
        idle(4);
        @(negedge clk);
        checks++;
        if (flush_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stats_flush got=%0d exp=2", flush_cnt);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_raw();
        test_no_match();
        test_branch();
        test_branch_raw();
        test_cache_miss();
        test_reset_mid();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
